// File: rtl/avalon_pkg.sv
// avalon_pkg: shared Avalon bus FSM type, address-decode constants and byte-lane merge
package avalon_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int BYTE_LANES = 4;
  localparam int WORD_SHIFT = 2;
  // word offset of a byte address from the window base; may exceed the array size
  function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> WORD_SHIFT;
  endfunction
  // replace only the byte lanes whose enable bit is set
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < BYTE_LANES; i++) m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/avalon_stall_ctrl.sv
// avalon_stall_ctrl: waitrequest stall FSM with registered request compare and accept generation
module avalon_stall_ctrl
  import avalon_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [29:0] addr,
  input  logic        load_en,
  output logic        accept,
  output logic        waitrequest
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(WAIT_CYCLES);
  state_t state;
  logic [CW-1:0] cnt;
  logic [29:0] req_addr;
  logic [1:0] req_op;
  logic req, match;
  assign req = read | write;
  assign match = req_addr == addr && req_op == {read, write};
  assign accept = req && !load_en && (WAIT_CYCLES == 0 || (state == WAIT && cnt == CMAX && match));
  assign waitrequest = req && !accept;
  // the launch cycle counts as the first stall cycle; a changed request relaunches, a preload freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      req_addr <= '0;
      req_op <= '0;
    end else if (!load_en) begin
      if (!req || accept) begin
        state <= IDLE;
        cnt <= '0;
      end else if (state == IDLE || !match) begin
        state <= WAIT;
        cnt <= CW'(1);
        req_addr <= addr;
        req_op <= {read, write};
      end else if (cnt != CMAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram: Avalon-MM slave memory with configurable waitrequest stall and preload port
module avalon_wait_ram
  import avalon_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        bus_err
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] bus_off, load_off;
  logic bus_ok, load_ok, accept;
  assign bus_off = word_off(address, BASE_ADDR);
  assign load_off = word_off(load_addr, BASE_ADDR);
  assign bus_ok = address >= BASE_ADDR && bus_off < 32'(MEM_WORDS);
  assign load_ok = load_addr >= BASE_ADDR && load_off < 32'(MEM_WORDS);
  assign readdata = accept && read && !write && bus_ok ? mem[bus_off[AW-1:0]] : '0;
  avalon_stall_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_ctrl (
    .clk(clk),
    .reset(reset),
    .read(read),
    .write(write),
    .addr(address[31:2]),
    .load_en(load_en),
    .accept(accept),
    .waitrequest(waitrequest)
  );
  // preload wins over the bus; accepted in-range writes merge enabled lanes unless reset aborts them
  always_ff @(posedge clk) begin
    if (load_en) begin
      if (load_ok) mem[load_off[AW-1:0]] <= load_data;
    end else if (accept && write && bus_ok && !reset) begin
      mem[bus_off[AW-1:0]] <= lane_merge(mem[bus_off[AW-1:0]], writedata, byteenable);
    end
  end
  // sticky flag for read+write collisions and out-of-range transfers
  always_ff @(posedge clk) begin
    if (reset) bus_err <= 1'b0;
    else if (accept && ((read && write) || !bus_ok)) bus_err <= 1'b1;
  end
endmodule
